// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, default widths, IR field map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_unit_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // Instruction register layout: opcode in the high nibble, rs/imm in the low nibble.
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int OPR_MSB = 3;
    localparam int OPR_LSB = 0;
    localparam int OPR_W   = OPR_MSB - OPR_LSB + 1;

    localparam logic [3:0] NOP_OPCODE = 4'h0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } fetchState_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: boot preset, absolute load (register or IR immediate), or increment.
// Latency: one cycle, new PC visible after the rising edge that applies the update.
// Backpressure: none; the caller gates loadPc/incPc so they only arrive when the fetch FSM allows.
//   Ports: CLK/CLB clock and async active-low reset; bootSet forces PC to 1 after the boot fetch;
//   loadPc/selPc/regData/operand select the jump target; incPc advances PC; pc is the current value.
module fetch_unit_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              CLB,
    input  logic              bootSet,
    input  logic              loadPc,
    input  logic              incPc,
    input  logic              selPc,
    input  logic [ADDR_W-1:0] regData,
    input  logic [OPR_W-1:0]  operand,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] jumpTarget;
    logic [ADDR_W-1:0] pcPlusOne;

    assign jumpTarget = selPc ? regData : {{(ADDR_W-OPR_W){1'b0}}, operand};
    // Natural wrap of the fixed-width add gives the 0xFF -> 0x00 rollover.
    assign pcPlusOne  = pc + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Priority: boot preset, then load (which swallows a concurrent increment), then increment.
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            pc <= '0;
        end else if (bootSet) begin
            pc <= {{(ADDR_W-1){1'b0}}, 1'b1};
        end else if (loadPc) begin
            pc <= jumpTarget;
        end else if (incPc) begin
            pc <= pcPlusOne;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues instruction-memory requests, captures IR, owns the PC via pc_reg.
// Latency: request edge then response edge; with zero-wait memory one fetch completes every two cycles.
// Backpressure: Stall=1 while booting or waiting on memory; controller strobes are ignored until READY.
//   Ports: CLK/CLB clock and async active-low reset; LoadIR/IncPC/SelPC/LoadPC/RegData controller side;
//   MemAddr/MemReq/MemData/MemValid instruction memory; Opcode/Operand decoded IR; PC; Stall.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              CLB,
    input  logic              LoadIR,
    input  logic              IncPC,
    input  logic              SelPC,
    input  logic              LoadPC,
    input  logic [ADDR_W-1:0] RegData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemReq,
    input  logic [DATA_W-1:0] MemData,
    input  logic              MemValid,
    output logic [3:0]        Opcode,
    output logic [3:0]        Operand,
    output logic [ADDR_W-1:0] PC,
    output logic              Stall
);

    localparam logic [DATA_W-1:0] IR_RESET = DATA_W'({NOP_OPCODE, {OPR_W{1'b0}}});

    fetchState_t       state;
    fetchState_t       nextState;
    logic [DATA_W-1:0] ir;
    logic              bootFlag;

    logic              reqStart;
    logic [ADDR_W-1:0] reqAddr;
    logic              fetchDone;
    logic              bootDone;
    logic              pcLoad;
    logic              pcInc;

    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            state <= BOOT;
        end else begin
            state <= nextState;
        end
    end

    // MemValid only matters in WAIT and controller strobes only in READY, so a response
    // straggling in after a reset abort cannot load IR until a fresh request is outstanding.
    always_comb begin
        nextState = state;
        reqStart  = 1'b0;
        reqAddr   = '0;
        fetchDone = 1'b0;
        bootDone  = 1'b0;
        pcLoad    = 1'b0;
        pcInc     = 1'b0;
        case (state)
            BOOT: begin
                reqStart  = 1'b1;
                nextState = WAIT;
            end
            WAIT: begin
                if (MemValid) begin
                    fetchDone = 1'b1;
                    bootDone  = bootFlag;
                    nextState = READY;
                end
            end
            READY: begin
                pcLoad = LoadPC;
                pcInc  = IncPC & ~LoadPC;
                if (LoadIR) begin
                    reqStart  = 1'b1;
                    reqAddr   = PC;  // pre-update PC, even when PC changes this same edge
                    nextState = WAIT;
                end
            end
            default: begin
                nextState = BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            ir       <= IR_RESET;
            MemReq   <= 1'b0;
            MemAddr  <= '0;
            bootFlag <= 1'b1;
        end else if (reqStart) begin
            MemReq  <= 1'b1;
            MemAddr <= reqAddr;
        end else if (fetchDone) begin
            MemReq   <= 1'b0;
            ir       <= MemData;
            bootFlag <= 1'b0;
        end
    end

    fetch_unit_pc_reg #(
        .ADDR_W (ADDR_W)
    ) u_pc_reg (
        .CLK     (CLK),
        .CLB     (CLB),
        .bootSet (bootDone),
        .loadPc  (pcLoad),
        .incPc   (pcInc),
        .selPc   (SelPC),
        .regData (RegData),
        .operand (ir[OPR_MSB:OPR_LSB]),
        .pc      (PC)
    );

    assign Opcode  = ir[OPC_MSB:OPC_LSB];
    assign Operand = ir[OPR_MSB:OPR_LSB];
    assign Stall   = (state != READY);

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    logic       CLK = 1'b0;
    logic       CLB = 1'b1;
    logic       LoadIR = 1'b0, IncPC = 1'b0, SelPC = 1'b0, LoadPC = 1'b0;
    logic [7:0] RegData = 8'h00;
    logic [7:0] MemAddr, MemData, PC;
    logic       MemReq, MemValid, Stall;
    logic [3:0] Opcode, Operand;

    fetch_unit dut (
        .CLK(CLK), .CLB(CLB), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
        .RegData(RegData), .MemAddr(MemAddr), .MemReq(MemReq), .MemData(MemData),
        .MemValid(MemValid), .Opcode(Opcode), .Operand(Operand), .PC(PC), .Stall(Stall)
    );

    always #5 CLK = ~CLK;

    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- instruction memory model ----------------
    logic [7:0] mem [256];
    int         memWait = 0;     // extra cycles before MemValid after the request is first seen
    logic       memPulse = 1'b0;
    logic [7:0] memDataQ = 8'h00;
    logic       injectValid = 1'b0;
    logic       busy = 1'b0;
    int         cnt = 0;
    logic [7:0] reqAddrM = 8'h00;

    assign MemValid = memPulse | injectValid;
    assign MemData  = injectValid ? 8'hEE : memDataQ;

    always @(negedge CLK) begin
        if (!CLB) begin
            busy = 1'b0;
            memPulse = 1'b0;
        end else if (memPulse) begin
            memPulse = 1'b0;
            busy = 1'b0;
        end else if (busy) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                memPulse = 1'b1;
                memDataQ = mem[reqAddrM];
            end
        end else if (MemReq) begin
            busy = 1'b1;
            reqAddrM = MemAddr;
            cnt = memWait;
            if (memWait == 0) begin
                memPulse = 1'b1;
                memDataQ = mem[reqAddrM];
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0] ir;
        logic [7:0] pc;
    } fetchExp_t;

    fetchExp_t  expFetch[$];
    logic [7:0] expReq[$];
    logic [7:0] curExpAddr = 8'h00;
    logic       prevStall = 1'b1;
    logic       prevReq = 1'b0;

    always @(negedge CLK) begin
        if (!CLB) begin
            prevStall = 1'b1;
            prevReq = 1'b0;
        end else begin
            if (MemReq && !prevReq) begin
                if (expReq.size() == 0) begin
                    nCmp++; nBad++;
                    $display("FAIL req_unexpected: MemReq rose at addr 0x%0h, no request expected", MemAddr);
                end else begin
                    curExpAddr = expReq.pop_front();
                    chk("req_addr", MemAddr, curExpAddr);
                end
            end else if (MemReq && prevReq) begin
                chk("req_addr_stable", MemAddr, curExpAddr);
            end
            if (!Stall && prevStall) begin
                if (expFetch.size() == 0) begin
                    nCmp++; nBad++;
                    $display("FAIL fetch_unexpected: fetch completed with IR op 0x%0h, none expected", Opcode);
                end else begin
                    fetchExp_t e;
                    e = expFetch.pop_front();
                    chk("fetch_opcode", Opcode, e.ir[7:4]);
                    chk("fetch_operand", Operand, e.ir[3:0]);
                    chk("fetch_pc", PC, e.pc);
                    chk("fetch_memreq_dropped", MemReq, 1'b0);
                end
            end
            prevStall = Stall;
            prevReq = MemReq;
        end
    end

    // ---------------- reference model + stimulus ----------------
    logic [7:0] mPc = 8'h00;
    logic [7:0] mIr = 8'h00;

    task automatic waitReady(input string tag, output int n);
        n = 0;
        while (Stall && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (Stall) begin
            nCmp++; nBad++;
            $display("FAIL %s_timeout: Stall still 1 after 100 cycles, expected 0", tag);
        end
    endtask

    // Called at a negedge with the unit in READY; drives the strobes for one cycle.
    task automatic issue(input bit li, input bit ip, input bit lp, input bit sel, input logic [7:0] rd);
        logic [7:0] nxt;
        if (lp)      nxt = sel ? rd : {4'h0, mIr[3:0]};
        else if (ip) nxt = 8'((int'(mPc) + 1) % 256);
        else         nxt = mPc;
        if (li) begin
            expReq.push_back(mPc);
            expFetch.push_back({mem[mPc], nxt});
            mIr = mem[mPc];
        end
        mPc = nxt;
        LoadIR = li; IncPC = ip; LoadPC = lp; SelPC = sel; RegData = rd;
        @(negedge CLK);
        LoadIR = 1'b0; IncPC = 1'b0; LoadPC = 1'b0; SelPC = 1'b0;
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_pc"}, PC, 8'h00);
        chk({tag, "_opcode"}, Opcode, 4'h0);
        chk({tag, "_operand"}, Operand, 4'h0);
        chk({tag, "_memreq"}, MemReq, 1'b0);
        chk({tag, "_memaddr"}, MemAddr, 8'h00);
        chk({tag, "_stall"}, Stall, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h15;
        mem[1] = 8'hB0;
        mem[2] = 8'h7A;

        // Power-on reset and the boot fetch with a slow memory.
        #1 CLB = 1'b0;
        repeat (2) @(negedge CLK);
        chkReset("rst");
        memWait = 3;
        expReq.push_back(8'h00);
        expFetch.push_back({mem[0], 8'h01});
        mPc = 8'h01;
        mIr = mem[0];
        CLB = 1'b1;
        n = 0;
        while (Stall && n < 50) begin
            n++;
            @(negedge CLK);
        end
        chk("boot_stall_cycles", n, 5);
        chk("boot_opcode", Opcode, 4'h1);
        chk("boot_operand", Operand, 4'h5);
        chk("boot_pc", PC, 8'h01);

        // Fetch + increment together, zero-wait memory: two cycles per fetch.
        memWait = 0;
        issue(1, 1, 0, 0, 8'h00);
        waitReady("fetch_inc", n);
        chk("zero_wait_stall_cycles", n, 1);
        chk("fetch_inc_pc", PC, 8'h02);
        chk("fetch_inc_opcode", Opcode, 4'hB);

        // Load IR = 0x7A, then PC loads from the immediate, then from the register.
        issue(1, 0, 0, 0, 8'h00);
        waitReady("fetch_7a", n);
        issue(0, 1, 1, 0, 8'h00);
        chk("loadpc_imm_no_inc", PC, 8'h0A);
        issue(0, 0, 1, 1, 8'h3C);
        chk("loadpc_reg", PC, 8'h3C);

        // Increment wraps at the top of the address space.
        issue(0, 0, 1, 1, 8'hFF);
        issue(0, 1, 0, 0, 8'h00);
        chk("pc_wrap", PC, 8'h00);

        // Fetch and jump in the same cycle: fetch from the old PC, PC takes the target.
        issue(1, 0, 1, 1, 8'h40);
        waitReady("fetch_jump", n);
        chk("fetch_jump_pc", PC, 8'h40);

        // Strobes pulsed while waiting on memory are ignored.
        memWait = 4;
        issue(1, 0, 0, 0, 8'h00);
        LoadIR = 1'b1; IncPC = 1'b1; LoadPC = 1'b1; SelPC = 1'b1; RegData = 8'h99;
        repeat (2) @(negedge CLK);
        LoadIR = 1'b0; IncPC = 1'b0; LoadPC = 1'b0; SelPC = 1'b0;
        waitReady("wait_strobes", n);
        chk("wait_strobes_pc", PC, mPc);

        // Spurious MemValid in READY changes nothing.
        injectValid = 1'b1;
        @(negedge CLK);
        injectValid = 1'b0;
        @(negedge CLK);
        chk("spurious_stall", Stall, 1'b0);
        chk("spurious_pc", PC, mPc);
        chk("spurious_opcode", Opcode, mIr[7:4]);
        chk("spurious_operand", Operand, mIr[3:0]);
        chk("spurious_memreq", MemReq, 1'b0);

        // Randomised controller traffic against the model.
        for (int k = 0; k < 150; k++) begin
            bit li, ip, lp, sel;
            logic [7:0] rd;
            waitReady("rand", n);
            li  = 1'($urandom_range(0, 1));
            ip  = 1'($urandom_range(0, 1));
            lp  = 1'($urandom_range(0, 1));
            sel = 1'($urandom_range(0, 1));
            rd  = 8'($urandom);
            memWait = $urandom_range(0, 3);
            issue(li, ip, lp, sel, rd);
            if (!li) chk("rand_pc", PC, mPc);
        end
        waitReady("rand_end", n);

        // Reset in the middle of a fetch aborts it; a late MemValid is ignored.
        memWait = 6;
        issue(1, 0, 0, 0, 8'h00);
        repeat (2) @(negedge CLK);
        CLB = 1'b0;
        expReq.delete();
        expFetch.delete();
        #1;
        chkReset("midwait_rst");
        mPc = 8'h00;
        mIr = 8'h00;
        @(negedge CLK);
        @(negedge CLK);
        memWait = 2;
        expReq.push_back(8'h00);
        expFetch.push_back({mem[0], 8'h01});
        CLB = 1'b1;
        injectValid = 1'b1;
        @(negedge CLK);
        injectValid = 1'b0;
        chk("abort_opcode", Opcode, 4'h0);
        chk("abort_operand", Operand, 4'h0);
        chk("reboot_memreq", MemReq, 1'b1);
        chk("reboot_memaddr", MemAddr, 8'h00);
        mPc = 8'h01;
        mIr = mem[0];
        waitReady("reboot", n);
        chk("reboot_pc", PC, 8'h01);

        repeat (3) @(negedge CLK);
        chk("queues_drained", 32'(expReq.size() + expFetch.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
